move_selector: RTL and testbench

MOVE_SELECTOR -- requirements
Module: move_selector

---
 rtl/move_selector.sv | 171 +++++++++++++++++
 tb/tb_move_selector.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_selector.sv
// move_selector: scans nine per-square candidate scores, one beat per square. It returns the
// highest-scoring free square; on a tie the lowest square index wins. The result is held under
// a valid/ready handshake.
// Optional feature: define MOVE_SEL_ERR_EN to add the 'err' output. 'err' is high together
// with move_valid when no free square exists.
module move_selector #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         start,
    input  logic [8:0]   occupied,
    input  logic [N-1:0] score,
    input  logic         score_valid,
    output logic         score_ready,
    output logic         move_valid,
    input  logic         move_ready,
    output logic [3:0]   move_idx,
    output logic [8:0]   move_onehot,
    output logic [N-1:0] best_score,
`ifdef MOVE_SEL_ERR_EN
    output logic         err,
`endif
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    localparam logic [3:0] NoMove  = 4'hF;
    localparam logic [3:0] LastSq  = 4'd8;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [8:0]     occ_q, occ_d;
    logic           best_valid_q, best_valid_d;
    logic [3:0]     best_idx_q, best_idx_d;
    logic [N-1:0]   best_score_q, best_score_d;
    logic [3:0]     res_idx_q, res_idx_d;
    logic [8:0]     res_onehot_q, res_onehot_d;
    logic [N-1:0]   res_score_q, res_score_d;
    logic           res_none_q, res_none_d;

    logic           start_acc;
    logic           beat_acc;
    logic           last_beat;
    logic           take;
    logic           handshake;

    // State register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StScan;
            StScan:  if (last_beat) state_d = StDone;
            StDone:  if (move_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        score_ready = (state_q == StScan);
        move_valid  = (state_q == StDone);
        busy        = (state_q != StIdle);
    end

    assign start_acc = (state_q == StIdle) && start;
    assign beat_acc  = (state_q == StScan) && score_valid;
    assign last_beat = beat_acc && (cnt_q == LastSq);
    assign handshake = (state_q == StDone) && move_ready;
    // Strict compare: an equal score on a later square never displaces the held best.
    assign take      = beat_acc && !occ_q[cnt_q] && (!best_valid_q || (score > best_score_q));

    // Scan datapath: beat counter, running best, result capture on the final beat
    always_comb begin
        cnt_d        = cnt_q;
        occ_d        = occ_q;
        best_valid_d = best_valid_q;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        res_idx_d    = res_idx_q;
        res_onehot_d = res_onehot_q;
        res_score_d  = res_score_q;
        res_none_d   = res_none_q;

        if (start_acc) begin
            occ_d        = occupied;
            cnt_d        = 4'd0;
            best_valid_d = 1'b0;
            best_idx_d   = NoMove;
            best_score_d = '0;
        end

        if (beat_acc) begin
            cnt_d = last_beat ? 4'd0 : cnt_q + 4'd1;
            if (take) begin
                best_valid_d = 1'b1;
                best_idx_d   = cnt_q;
                best_score_d = score;
            end
        end

        // Capture the final result from the updated best so the last beat is included.
        if (last_beat) begin
            if (best_valid_d) begin
                res_idx_d    = best_idx_d;
                res_onehot_d = 9'd1 << best_idx_d;
                res_score_d  = best_score_d;
                res_none_d   = 1'b0;
            end else begin
                res_idx_d    = NoMove;
                res_onehot_d = '0;
                res_score_d  = '0;
                res_none_d   = 1'b1;
            end
        end

        if (handshake) begin
            res_idx_d    = NoMove;
            res_onehot_d = '0;
            res_score_d  = '0;
            res_none_d   = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cnt_q        <= 4'd0;
            occ_q        <= '0;
            best_valid_q <= 1'b0;
            best_idx_q   <= NoMove;
            best_score_q <= '0;
            res_idx_q    <= NoMove;
            res_onehot_q <= '0;
            res_score_q  <= '0;
            res_none_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            occ_q        <= occ_d;
            best_valid_q <= best_valid_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
            res_idx_q    <= res_idx_d;
            res_onehot_q <= res_onehot_d;
            res_score_q  <= res_score_d;
            res_none_q   <= res_none_d;
        end
    end

    assign move_idx    = res_idx_q;
    assign move_onehot = res_onehot_q;
    assign best_score  = res_score_q;

`ifdef MOVE_SEL_ERR_EN
    assign err = res_none_q;
`else
    logic unused_none;
    assign unused_none = res_none_q;
`endif

endmodule

// File: tb/tb_move_selector.sv
// Directed testbench for move_selector; checks results, handshake, stalls and reset.
module tb_move_selector;

    localparam int unsigned N = 8;

    logic         clk;
    logic         resetb;
    logic         start;
    logic [8:0]   occupied;
    logic [N-1:0] score;
    logic         score_valid;
    logic         score_ready;
    logic         move_valid;
    logic         move_ready;
    logic [3:0]   move_idx;
    logic [8:0]   move_onehot;
    logic [N-1:0] best_score;
    logic         busy;
`ifdef MOVE_SEL_ERR_EN
    logic         err;
`endif

    int tests_run;
    int tests_failed;

    logic [N-1:0] scores_v [9];

    move_selector #(.N(N)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .start      (start),
        .occupied   (occupied),
        .score      (score),
        .score_valid(score_valid),
        .score_ready(score_ready),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_idx   (move_idx),
        .move_onehot(move_onehot),
        .best_score (best_score),
`ifdef MOVE_SEL_ERR_EN
        .err        (err),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ref_scores();
        scores_v[0] = 8'd3; scores_v[1] = 8'd9; scores_v[2] = 8'd1;
        scores_v[3] = 8'd9; scores_v[4] = 8'd0; scores_v[5] = 8'd0;
        scores_v[6] = 8'd0; scores_v[7] = 8'd0; scores_v[8] = 8'd2;
    endtask

    // Starts a scan and feeds beats 0..last; optional one-idle-cycle gaps between beats.
    task automatic scan(input logic [8:0] occ, input bit gaps, input int last);
        start    = 1'b1;
        occupied = occ;
        tick();
        start    = 1'b0;
        occupied = 9'h0AA;
        tests_run++;
        if (score_ready !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL scan_enter: score_ready=%b busy=%b, required 1 1", score_ready, busy);
        end
        for (int k = 0; k <= last; k++) begin
            if (gaps) begin
                score_valid = 1'b0;
                score       = 8'hFF;
                tick();
            end
            score       = scores_v[k];
            score_valid = 1'b1;
            tick();
            if (k < 8 && move_valid !== 1'b0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL early_valid: beat %0d move_valid=%b, required 0", k, move_valid);
            end
        end
        score_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetb = 1'b0; start = 1'b0; occupied = '0; score = '0;
        score_valid = 1'b0; move_ready = 1'b0;
        #22;
        tests_run++;
        if ({move_valid, score_ready, busy, move_idx, move_onehot, best_score} !==
            {1'b0, 1'b0, 1'b0, 4'hF, 9'h000, 8'd0}) begin
            tests_failed++;
            $display("FAIL reset_state: v=%b r=%b b=%b idx=%h oh=%h s=%0d, required 0 0 0 f 000 0",
                     move_valid, score_ready, busy, move_idx, move_onehot, best_score);
        end
`ifdef MOVE_SEL_ERR_EN
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_err: err=%b, required 0", err);
        end
`endif
        resetb = 1'b1;
        tick();
        tests_run++;
        if (busy !== 1'b0 || move_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_start: busy=%b v=%b, required 0 0", busy, move_valid);
        end
    endtask

    task automatic test_basic();
        load_ref_scores();
        scan(9'h000, 1'b0, 8);
        tests_run++;
        if (move_valid !== 1'b1 || score_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_latency: v=%b r=%b, required 1 0", move_valid, score_ready);
        end
        tests_run++;
        if (move_idx !== 4'd1 || move_onehot !== 9'h002 || best_score !== 8'd9) begin
            tests_failed++;
            $display("FAIL basic_result: idx=%0d oh=%h s=%0d, required 1 002 9",
                     move_idx, move_onehot, best_score);
        end
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
        tests_run++;
        if (move_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_release: v=%b busy=%b, required 0 0", move_valid, busy);
        end
    endtask

    task automatic test_occupied();
        load_ref_scores();
        scan(9'h002, 1'b0, 8);
        tests_run++;
        if (move_idx !== 4'd3 || move_onehot !== 9'h008 || best_score !== 8'd9) begin
            tests_failed++;
            $display("FAIL occ_result: idx=%0d oh=%h s=%0d, required 3 008 9",
                     move_idx, move_onehot, best_score);
        end
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
    endtask

    task automatic test_all_occupied();
        load_ref_scores();
        scan(9'h1FF, 1'b0, 8);
        tests_run++;
        if (move_valid !== 1'b1 || move_idx !== 4'hF || move_onehot !== 9'h000 ||
            best_score !== 8'd0) begin
            tests_failed++;
            $display("FAIL full_result: v=%b idx=%h oh=%h s=%0d, required 1 f 000 0",
                     move_valid, move_idx, move_onehot, best_score);
        end
`ifdef MOVE_SEL_ERR_EN
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_err: err=%b, required 1", err);
        end
`endif
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
`ifdef MOVE_SEL_ERR_EN
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_err_clear: err=%b, required 0", err);
        end
`endif
    endtask

    task automatic test_stall();
        load_ref_scores();
        scan(9'h000, 1'b1, 8);
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            tests_run++;
            if (move_valid !== 1'b1 || move_idx !== 4'd1 || move_onehot !== 9'h002 ||
                best_score !== 8'd9) begin
                tests_failed++;
                $display("FAIL stall_hold: cycle %0d v=%b idx=%0d oh=%h s=%0d, required 1 1 002 9",
                         c, move_valid, move_idx, move_onehot, best_score);
            end
            tick();
        end
        // Handshake with start also high: start must not begin a new scan.
        start      = 1'b1;
        move_ready = 1'b1;
        tick();
        start      = 1'b0;
        move_ready = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0 || score_ready !== 1'b0 || move_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_start_ignored: busy=%b r=%b v=%b, required 0 0 0",
                     busy, score_ready, move_valid);
        end
    endtask

    task automatic test_reset_mid();
        load_ref_scores();
        scan(9'h000, 1'b0, 4);
        resetb = 1'b0;
        #2;
        tests_run++;
        if ({move_valid, score_ready, busy, move_idx, move_onehot, best_score} !==
            {1'b0, 1'b0, 1'b0, 4'hF, 9'h000, 8'd0}) begin
            tests_failed++;
            $display("FAIL midreset_state: v=%b r=%b b=%b idx=%h oh=%h s=%0d, required 0 0 0 f 000 0",
                     move_valid, score_ready, busy, move_idx, move_onehot, best_score);
        end
        #10;
        resetb = 1'b1;
        tick();
        for (int k = 0; k < 9; k++) scores_v[k] = 8'd7;
        scan(9'h000, 1'b0, 8);
        tests_run++;
        if (move_valid !== 1'b1 || move_idx !== 4'd0 || move_onehot !== 9'h001 ||
            best_score !== 8'd7) begin
            tests_failed++;
            $display("FAIL midreset_rescan: v=%b idx=%0d oh=%h s=%0d, required 1 0 001 7",
                     move_valid, move_idx, move_onehot, best_score);
        end
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
    endtask

    // Two scans with the later best on the last square, back to back.
    task automatic test_back_to_back();
        for (int k = 0; k < 9; k++) scores_v[k] = 8'(k);
        scan(9'h000, 1'b0, 8);
        tests_run++;
        if (move_idx !== 4'd8 || move_onehot !== 9'h100 || best_score !== 8'd8) begin
            tests_failed++;
            $display("FAIL b2b_first: idx=%0d oh=%h s=%0d, required 8 100 8",
                     move_idx, move_onehot, best_score);
        end
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
        scan(9'h100, 1'b0, 8);
        tests_run++;
        if (move_idx !== 4'd7 || move_onehot !== 9'h080 || best_score !== 8'd7) begin
            tests_failed++;
            $display("FAIL b2b_second: idx=%0d oh=%h s=%0d, required 7 080 7",
                     move_idx, move_onehot, best_score);
        end
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_occupied();
        test_all_occupied();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
